// File: rtl/risc16_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// risc16_ctrl_fsm
//   Multi-cycle control unit for the 16-bit RiSC-16 core. Sequences each
//   instruction through FETCH, DECODE, EXEC, optional MEM, and WB, and drives
//   the ALU strobes, operand muxes, register-file write, PC update and the
//   instruction/data memory handshakes. A JALR with a non-zero imm7 halts the
//   core until reset.
//
// Ports
//   clk, rst_n     core clock, asynchronous active-low reset
//   instr          instruction word from imem (valid with imem_valid)
//   imem_req/valid instruction fetch handshake
//   dmem_req/we    data access request (we: 1 = store, 0 = load)
//   dmem_ready     data access complete
//   eq_out         ALU equality result, used for BEQ resolution
//   ADD/NAND/PASS1/EQ  ALU operation strobes
//   ir_we          load the instruction register from instr
//   src1_sel       0 = rf port1, 1 = PC, 2 = imm10<<6
//   src2_sel       0 = rf port2, 1 = sign-extended imm7
//   rf_we          write regA
//   rf_wd_sel      0 = alu_out, 1 = dmem rdata, 2 = PC+1
//   pc_we, pc_sel  PC update; sel 0 = PC+1, 1 = PC+1+simm7, 2 = alu_out
//   halted         core halted
// -----------------------------------------------------------------------------
module risc16_ctrl_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    output logic        imem_req,
    input  logic        imem_valid,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        eq_out,
    output logic        ADD,
    output logic        NAND,
    output logic        PASS1,
    output logic        EQ,
    output logic        ir_we,
    output logic [1:0]  src1_sel,
    output logic        src2_sel,
    output logic        rf_we,
    output logic [1:0]  rf_wd_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_JALR = 3'b111
    } opcode_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        taken_q, taken_d;

    // Registered outputs; *_d is the value for the state being entered.
    logic        imem_req_q, imem_req_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic        add_q, add_d;
    logic        nand_q, nand_d;
    logic        pass1_q, pass1_d;
    logic        eq_q, eq_d;
    logic [1:0]  src1_sel_q, src1_sel_d;
    logic        src2_sel_q, src2_sel_d;
    logic        rf_we_q, rf_we_d;
    logic [1:0]  rf_wd_sel_q, rf_wd_sel_d;
    logic        pc_we_q, pc_we_d;
    logic [1:0]  pc_sel_q, pc_sel_d;
    logic        halted_q, halted_d;

    // Instruction fields
    opcode_t     op;
    logic [2:0]  rega;
    logic [6:0]  imm7;
    logic        unused_regb;

    assign op          = opcode_t'(ir_q[15:13]);
    assign rega        = ir_q[12:10];
    assign imm7        = ir_q[6:0];
    // regB is steered by the datapath directly; the controller never needs it.
    assign unused_regb = ^ir_q[9:7];

    // Per-opcode decode
    logic        dec_add, dec_nand, dec_pass1, dec_eq;
    logic [1:0]  dec_src1;
    logic        dec_src2;
    logic        dec_writes_rf;
    logic [1:0]  dec_wd_sel;
    logic        is_mem, is_sw, is_beq, is_jalr;

    always_comb begin
        dec_add       = 1'b0;
        dec_nand      = 1'b0;
        dec_pass1     = 1'b0;
        dec_eq        = 1'b0;
        dec_src1      = 2'd0;
        dec_src2      = 1'b0;
        dec_writes_rf = 1'b0;
        dec_wd_sel    = 2'd0;
        unique case (op)
            OP_ADD: begin
                dec_add       = 1'b1;
                dec_writes_rf = 1'b1;
            end
            OP_ADDI: begin
                dec_add       = 1'b1;
                dec_src2      = 1'b1;
                dec_writes_rf = 1'b1;
            end
            OP_NAND: begin
                dec_nand      = 1'b1;
                dec_writes_rf = 1'b1;
            end
            OP_LUI: begin
                dec_pass1     = 1'b1;
                dec_src1      = 2'd2;
                dec_writes_rf = 1'b1;
            end
            OP_SW: begin
                dec_add  = 1'b1;
                dec_src2 = 1'b1;
            end
            OP_LW: begin
                dec_add       = 1'b1;
                dec_src2      = 1'b1;
                dec_writes_rf = 1'b1;
                dec_wd_sel    = 2'd1;
            end
            OP_BEQ: begin
                dec_eq = 1'b1;
            end
            OP_JALR: begin
                dec_pass1     = 1'b1;
                dec_writes_rf = 1'b1;
                dec_wd_sel    = 2'd2;
            end
            default: ;
        endcase
    end

    assign is_sw   = (op == OP_SW);
    assign is_mem  = (op == OP_SW) || (op == OP_LW);
    assign is_beq  = (op == OP_BEQ);
    assign is_jalr = (op == OP_JALR);

    // Next state plus the output values belonging to that next state, so that
    // every output except ir_we comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        taken_d     = taken_q;
        imem_req_d  = 1'b0;
        dmem_req_d  = 1'b0;
        dmem_we_d   = 1'b0;
        add_d       = 1'b0;
        nand_d      = 1'b0;
        pass1_d     = 1'b0;
        eq_d        = 1'b0;
        src1_sel_d  = 2'd0;
        src2_sel_d  = 1'b0;
        rf_we_d     = 1'b0;
        rf_wd_sel_d = 2'd0;
        pc_we_d     = 1'b0;
        pc_sel_d    = 2'd0;
        halted_d    = 1'b0;

        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (imem_valid) begin
                    state_d = S_DECODE;
                    ir_d    = instr;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                taken_d = is_beq & eq_out;
                if (is_mem) begin
                    state_d = S_MEM;
                end else if (is_jalr && (imm7 != '0)) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = S_WB;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        case (state_d)
            S_FETCH: imem_req_d = 1'b1;
            S_EXEC, S_MEM, S_WB: begin
                add_d      = dec_add;
                nand_d     = dec_nand;
                pass1_d    = dec_pass1;
                eq_d       = dec_eq;
                src1_sel_d = dec_src1;
                src2_sel_d = dec_src2;
                if (state_d == S_MEM) begin
                    dmem_req_d = 1'b1;
                    dmem_we_d  = is_sw;
                end
                if (state_d == S_WB) begin
                    pc_we_d     = 1'b1;
                    rf_we_d     = dec_writes_rf && (rega != '0);
                    rf_wd_sel_d = dec_wd_sel;
                    if (is_jalr) begin
                        pc_sel_d = 2'd2;
                    end else if (is_beq && taken_d) begin
                        pc_sel_d = 2'd1;
                    end
                end
            end
            S_HALT:  halted_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            taken_q     <= 1'b0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            add_q       <= 1'b0;
            nand_q      <= 1'b0;
            pass1_q     <= 1'b0;
            eq_q        <= 1'b0;
            src1_sel_q  <= 2'd0;
            src2_sel_q  <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_wd_sel_q <= 2'd0;
            pc_we_q     <= 1'b0;
            pc_sel_q    <= 2'd0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            taken_q     <= taken_d;
            imem_req_q  <= imem_req_d;
            dmem_req_q  <= dmem_req_d;
            dmem_we_q   <= dmem_we_d;
            add_q       <= add_d;
            nand_q      <= nand_d;
            pass1_q     <= pass1_d;
            eq_q        <= eq_d;
            src1_sel_q  <= src1_sel_d;
            src2_sel_q  <= src2_sel_d;
            rf_we_q     <= rf_we_d;
            rf_wd_sel_q <= rf_wd_sel_d;
            pc_we_q     <= pc_we_d;
            pc_sel_q    <= pc_sel_d;
            halted_q    <= halted_d;
        end
    end

    assign imem_req  = imem_req_q;
    // ir_we must coincide with the imem_valid cycle, so it cannot be a flop.
    assign ir_we     = imem_req_q & imem_valid;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign ADD       = add_q;
    assign NAND      = nand_q;
    assign PASS1     = pass1_q;
    assign EQ        = eq_q;
    assign src1_sel  = src1_sel_q;
    assign src2_sel  = src2_sel_q;
    assign rf_we     = rf_we_q;
    assign rf_wd_sel = rf_wd_sel_q;
    assign pc_we     = pc_we_q;
    assign pc_sel    = pc_sel_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_risc16_ctrl_fsm
//   Drives instructions through risc16_ctrl_fsm with random wait states and
//   random don't-care inputs, and compares every cycle's outputs against a
//   phase-level model of the instruction's expected behaviour.
// -----------------------------------------------------------------------------
module tb_risc16_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        imem_req, imem_valid;
    logic        dmem_req, dmem_we, dmem_ready;
    logic        eq_out;
    logic        ADD, NAND, PASS1, EQ;
    logic        ir_we;
    logic [1:0]  src1_sel;
    logic        src2_sel;
    logic        rf_we;
    logic [1:0]  rf_wd_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        halted;

    risc16_ctrl_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .eq_out     (eq_out),
        .ADD        (ADD),
        .NAND       (NAND),
        .PASS1      (PASS1),
        .EQ         (EQ),
        .ir_we      (ir_we),
        .src1_sel   (src1_sel),
        .src2_sel   (src2_sel),
        .rf_we      (rf_we),
        .rf_wd_sel  (rf_wd_sel),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       add;
        logic       nand_s;
        logic       pass1;
        logic       eq;
        logic [1:0] src1;
        logic       src2;
        logic       rf_we;
        logic [1:0] wd;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       halted;
    } outs_t;

    typedef enum int {P_IDLE, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_HALT} phase_t;

    typedef struct {
        outs_t  o;
        phase_t ph;
    } exp_t;

    exp_t  exp_q[$];
    outs_t last_obs [7];
    int    n_checks = 0;
    int    n_err    = 0;
    int    dreq_cnt = 0;
    int    halt_ireq_cnt = 0;

    // What the control unit must present during one phase of an instruction.
    function automatic outs_t model(input phase_t ph, input logic [15:0] ir,
                                    input logic taken, input logic valid);
        outs_t      o;
        logic [2:0] opc;
        logic [2:0] ra;
        o   = '0;
        opc = ir[15:13];
        ra  = ir[12:10];
        case (ph)
            P_FETCH: begin
                o.imem_req = 1'b1;
                o.ir_we    = valid;
            end
            P_EXEC, P_MEM, P_WB: begin
                case (opc)
                    3'd0, 3'd1, 3'd4, 3'd5: o.add = 1'b1;
                    3'd2:                   o.nand_s = 1'b1;
                    3'd3: begin o.pass1 = 1'b1; o.src1 = 2'd2; end
                    3'd6:                   o.eq = 1'b1;
                    default:                o.pass1 = 1'b1;
                endcase
                o.src2 = (opc == 3'd1) || (opc == 3'd4) || (opc == 3'd5);
                if (ph == P_MEM) begin
                    o.dmem_req = 1'b1;
                    o.dmem_we  = (opc == 3'd4);
                end
                if (ph == P_WB) begin
                    o.pc_we  = 1'b1;
                    o.pc_sel = (opc == 3'd7) ? 2'd2 : ((opc == 3'd6 && taken) ? 2'd1 : 2'd0);
                    o.rf_we  = (opc != 3'd4) && (opc != 3'd6) && (ra != 3'd0);
                    o.wd     = (opc == 3'd5) ? 2'd1 : ((opc == 3'd7) ? 2'd2 : 2'd0);
                end
            end
            P_HALT: o.halted = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o = {imem_req, ir_we, dmem_req, dmem_we, ADD, NAND, PASS1, EQ,
             src1_sel, src2_sel, rf_we, rf_wd_sel, pc_we, pc_sel, halted};
        return o;
    endfunction

    // Single compare process: one expectation per cycle, checked mid-cycle.
    initial begin
        exp_t  e;
        outs_t obs;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                obs = observe();
                n_checks++;
                if (obs !== e.o) begin
                    n_err++;
                    $display("FAIL cycle_%s at %0t: got %h expected %h",
                             e.ph.name(), $time, obs, e.o);
                end
                last_obs[int'(e.ph)] = obs;
                if (obs.dmem_req) dreq_cnt++;
                if (e.ph == P_HALT && obs.imem_req) halt_ireq_cnt++;
            end
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        n_checks++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Inputs are set at posedge+1; the expectation covers the current cycle.
    task automatic step(input outs_t o, input phase_t ph);
        exp_t e;
        e.o  = o;
        e.ph = ph;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step('0, P_IDLE);
        step('0, P_IDLE);
        rst_n = 1'b1;
        step('0, P_IDLE);
    endtask

    task automatic run_instr(input logic [15:0] ir, input int unsigned fw,
                             input int unsigned mw, input logic eqv);
        logic [2:0] opc;
        opc = ir[15:13];
        for (int unsigned i = 0; i <= fw; i++) begin
            imem_valid = (i == fw);
            instr      = (i == fw) ? ir : 16'($urandom);
            dmem_ready = 1'($urandom);
            eq_out     = 1'($urandom);
            step(model(P_FETCH, ir, 1'b0, imem_valid), P_FETCH);
        end
        instr      = 16'($urandom);
        imem_valid = 1'($urandom);
        step(model(P_DECODE, ir, 1'b0, 1'b0), P_DECODE);
        eq_out     = eqv;
        imem_valid = 1'($urandom);
        step(model(P_EXEC, ir, 1'b0, 1'b0), P_EXEC);
        eq_out = 1'($urandom);
        if (opc == 3'd4 || opc == 3'd5) begin
            for (int unsigned j = 0; j <= mw; j++) begin
                dmem_ready = (j == mw);
                imem_valid = 1'($urandom);
                step(model(P_MEM, ir, 1'b0, 1'b0), P_MEM);
            end
        end
        if (opc == 3'd7 && ir[6:0] != 7'd0) begin
            for (int k = 0; k < 4; k++) begin
                imem_valid = 1'($urandom);
                dmem_ready = 1'($urandom);
                step(model(P_HALT, ir, 1'b0, 1'b0), P_HALT);
            end
            do_reset();
        end else begin
            dmem_ready = 1'($urandom);
            imem_valid = 1'($urandom);
            step(model(P_WB, ir, eqv, 1'b0), P_WB);
        end
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic mid_mem_reset();
        logic [15:0] ir;
        ir         = 16'hA885;
        imem_valid = 1'b1;
        instr      = ir;
        step(model(P_FETCH, ir, 1'b0, 1'b1), P_FETCH);
        imem_valid = 1'b0;
        step(model(P_DECODE, ir, 1'b0, 1'b0), P_DECODE);
        step(model(P_EXEC, ir, 1'b0, 1'b0), P_EXEC);
        dmem_ready = 1'b0;
        step(model(P_MEM, ir, 1'b0, 1'b0), P_MEM);
        #1;
        chk("mid_dmem_req_before_reset", int'(dmem_req), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_dmem_req_async_drop", int'(dmem_req), 0);
        chk("mid_rf_we", int'(rf_we), 0);
        chk("mid_pc_we", int'(pc_we), 0);
        chk("mid_ADD", int'(ADD), 0);
        step('0, P_IDLE);
        step('0, P_IDLE);
        rst_n = 1'b1;
        step('0, P_IDLE);
    endtask

    initial begin
        logic [15:0] r;
        rst_n      = 1'b0;
        instr      = '0;
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        eq_out     = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(16'h0481, 0, 0, 1'b0);
        chk("add_wb_ADD", int'(last_obs[P_WB].add), 1);
        chk("add_wb_rf_we", int'(last_obs[P_WB].rf_we), 1);
        chk("add_wb_wd_sel", int'(last_obs[P_WB].wd), 0);
        chk("add_wb_pc_we", int'(last_obs[P_WB].pc_we), 1);
        chk("add_wb_pc_sel", int'(last_obs[P_WB].pc_sel), 0);

        run_instr(16'h0082, 0, 0, 1'b0);
        chk("add_r0_rf_we", int'(last_obs[P_WB].rf_we), 0);
        chk("add_r0_pc_we", int'(last_obs[P_WB].pc_we), 1);

        dreq_cnt = 0;
        run_instr(16'hA885, 0, 3, 1'b0);
        chk("lw_dmem_req_cycles", dreq_cnt, 4);
        chk("lw_dmem_we", int'(last_obs[P_MEM].dmem_we), 0);
        chk("lw_wb_rf_we", int'(last_obs[P_WB].rf_we), 1);
        chk("lw_wb_wd_sel", int'(last_obs[P_WB].wd), 1);

        run_instr(16'hC57E, 0, 0, 1'b1);
        chk("beq_t_exec_EQ", int'(last_obs[P_EXEC].eq), 1);
        chk("beq_t_decode_EQ", int'(last_obs[P_DECODE].eq), 0);
        chk("beq_t_pc_sel", int'(last_obs[P_WB].pc_sel), 1);
        chk("beq_t_rf_we", int'(last_obs[P_WB].rf_we), 0);
        run_instr(16'hC57E, 0, 0, 1'b0);
        chk("beq_nt_pc_sel", int'(last_obs[P_WB].pc_sel), 0);
        chk("beq_nt_rf_we", int'(last_obs[P_WB].rf_we), 0);

        run_instr(16'hEE00, 0, 0, 1'b0);
        chk("jalr_exec_PASS1", int'(last_obs[P_EXEC].pass1), 1);
        chk("jalr_wb_rf_we", int'(last_obs[P_WB].rf_we), 1);
        chk("jalr_wb_wd_sel", int'(last_obs[P_WB].wd), 2);
        chk("jalr_wb_pc_sel", int'(last_obs[P_WB].pc_sel), 2);

        halt_ireq_cnt = 0;
        run_instr(16'hE001, 0, 0, 1'b0);
        chk("halt_halted", int'(last_obs[P_HALT].halted), 1);
        chk("halt_no_imem_req", halt_ireq_cnt, 0);

        mid_mem_reset();
        run_instr(16'h0481, 1, 0, 1'b0);

        for (int n = 0; n < 250; n++) begin
            r = 16'($urandom);
            if (r[15:13] == 3'd7 && ($urandom % 4) != 0) r[6:0] = '0;
            run_instr(r, $urandom % 4, $urandom % 4, 1'($urandom));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
